// File: rtl/echo_ctrl.sv
// echo_ctrl: circular-buffer echo controller driving memory_mod addresses/writes and producing a dry/wet mix
module echo_ctrl #(
  parameter int DEPTH = 29280,
  parameter int AW = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic signed [15:0]   smp_in,
  input  logic                 smp_valid,
  input  logic [AW-1:0]        delay_len,
  input  logic [7:0]           feedback,
  input  logic [7:0]           mix,
  output logic signed [15:0]   smp_out,
  output logic                 out_valid,
  output logic                 ready,
  output logic                 overrun,
  output logic                 mem_w_en,
  output logic [15:0]          mem_d_in,
  output logic [AW-1:0]        mem_w_addr,
  output logic [AW-1:0]        mem_r_addr,
  input  logic [15:0]          mem_d_out
);
  typedef enum logic [2:0] {CLEAR, IDLE, RD, CALC, WR} state_t;
  localparam logic [AW-1:0] DMAX = AW'(DEPTH - 1);
  localparam logic [AW-1:0] DW = AW'(DEPTH);
  state_t state, state_n;
  logic [AW-1:0] wptr, clr_addr, d;
  logic signed [15:0] smp_q;
  logic [7:0] fb_q, mix_q;
  logic signed [26:0] wet_x, smp_x, fb_x, mix_x, dry_x, fb_sum, mix_sum;
  function automatic logic [15:0] sat16(input logic signed [26:0] v);
    return v > 27'sd32767 ? 16'h7fff : v < -27'sd32768 ? 16'h8000 : v[15:0];
  endfunction
  assign ready = state == IDLE;
  assign d = delay_len == '0 ? AW'(1) : delay_len > DMAX ? DMAX : delay_len;
  assign wet_x = {{11{mem_d_out[15]}}, mem_d_out};
  assign smp_x = {{11{smp_q[15]}}, smp_q};
  assign fb_x = {19'd0, fb_q};
  assign mix_x = {19'd0, mix_q};
  assign dry_x = 27'sd256 - mix_x;
  assign fb_sum = smp_x + ((wet_x * fb_x) >>> 8);
  assign mix_sum = (smp_x * dry_x + wet_x * mix_x) >>> 8;
  always_ff @(posedge clk) state <= rst ? CLEAR : state_n;
  // CLEAR ends once the write of the last address is on the memory port
  always_comb begin
    state_n = state;
    state_n = state == CLEAR ? ((mem_w_en && mem_w_addr == DMAX) ? IDLE : CLEAR) :
              state == IDLE  ? (smp_valid ? RD : IDLE) :
              state == RD    ? CALC :
              state == CALC  ? WR : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      clr_addr <= '0;
      smp_out <= '0;
      out_valid <= 1'b0;
      overrun <= 1'b0;
      mem_w_en <= 1'b0;
      mem_w_addr <= '0;
      mem_d_in <= '0;
      mem_r_addr <= '0;
      smp_q <= '0;
      fb_q <= '0;
      mix_q <= '0;
    end else begin
      overrun <= smp_valid && state != IDLE;
      out_valid <= state == CALC;
      mem_w_en <= (state == CLEAR && state_n == CLEAR) || state == CALC;
      mem_w_addr <= state == CALC ? wptr : clr_addr;
      mem_d_in <= state == CALC ? sat16(fb_sum) : 16'h0000;
      clr_addr <= state == CLEAR ? clr_addr + 1'b1 : clr_addr;
      if (state == IDLE && smp_valid) begin
        smp_q <= smp_in;
        fb_q <= feedback;
        mix_q <= mix;
        mem_r_addr <= wptr >= d ? wptr - d : wptr + DW - d;
      end
      if (state == CALC) smp_out <= sat16(mix_sum);
      if (state == WR) wptr <= wptr == DMAX ? '0 : wptr + 1'b1;
    end
  end
endmodule

// File: tb/tb_echo_ctrl.sv
// tb_echo_ctrl: scoreboard bench for echo_ctrl against a behavioural memory and reference echo model
module tb_echo_ctrl;
  localparam int DEPTH = 29280;
  localparam int SD = 8;
  localparam int AW = 15;
  typedef struct packed {
    logic [15:0] out;
    logic [15:0] wd;
    logic [AW-1:0] wa;
    logic [AW-1:0] ra;
  } exp_t;
  logic clk = 0, rst = 1, smp_valid = 0, use_small = 0;
  logic signed [15:0] smp_in = 0;
  logic [AW-1:0] delay_len = 0;
  logic [7:0] feedback = 0, mix = 0;
  logic signed [15:0] b_out, s_out;
  logic b_valid, s_valid, b_ready, s_ready, b_ovr, s_ovr, b_wen, s_wen;
  logic [15:0] b_din, s_din, b_dout = 0, s_dout = 0;
  logic [AW-1:0] b_wa, s_wa, b_ra, s_ra;
  logic [15:0] bmem [DEPTH];
  logic [15:0] smem [SD];
  logic o_valid, o_ready, o_ovr, o_wen;
  logic [15:0] o_out, o_din;
  logic [AW-1:0] o_wa, o_ra;
  int n_cmp = 0, n_fail = 0;
  int ref_mem [32768];
  int ref_wptr, ref_depth;
  exp_t exp_q[$];

  echo_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .smp_in(smp_in), .smp_valid(smp_valid), .delay_len(delay_len),
    .feedback(feedback), .mix(mix), .smp_out(b_out), .out_valid(b_valid), .ready(b_ready),
    .overrun(b_ovr), .mem_w_en(b_wen), .mem_d_in(b_din), .mem_w_addr(b_wa), .mem_r_addr(b_ra),
    .mem_d_out(b_dout));
  echo_ctrl #(.DEPTH(SD), .AW(AW)) dut_small (
    .clk(clk), .rst(rst), .smp_in(smp_in), .smp_valid(smp_valid), .delay_len(delay_len),
    .feedback(feedback), .mix(mix), .smp_out(s_out), .out_valid(s_valid), .ready(s_ready),
    .overrun(s_ovr), .mem_w_en(s_wen), .mem_d_in(s_din), .mem_w_addr(s_wa), .mem_r_addr(s_ra),
    .mem_d_out(s_dout));

  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (b_wen) bmem[b_wa] <= b_din;
    b_dout <= bmem[b_ra];
    if (s_wen) smem[s_wa[2:0]] <= s_din;
    s_dout <= smem[s_ra[2:0]];
  end
  assign o_valid = use_small ? s_valid : b_valid;
  assign o_ready = use_small ? s_ready : b_ready;
  assign o_ovr = use_small ? s_ovr : b_ovr;
  assign o_wen = use_small ? s_wen : b_wen;
  assign o_out = use_small ? s_out : b_out;
  assign o_din = use_small ? s_din : b_din;
  assign o_wa = use_small ? s_wa : b_wa;
  assign o_ra = use_small ? s_ra : b_ra;

  function automatic int sat(input int v);
    return v > 32767 ? 32767 : v < -32768 ? -32768 : v;
  endfunction
  function automatic void model_reset(input int depth);
    ref_depth = depth;
    ref_wptr = 0;
    for (int i = 0; i < 32768; i++) ref_mem[i] = 0;
    exp_q.delete();
  endfunction

  task automatic drive(input int s, input int dl, input int fb, input int mx, input bit push,
                       output logic [AW-1:0] ra);
    int d, r, wet, f, m;
    for (int i = 0; i < 40000 && !o_ready; i++) begin @(posedge clk); #1; end
    if (!o_ready) begin
      n_cmp++; n_fail++;
      $display("FAIL drive_ready: ready=%b required 1", o_ready);
    end
    smp_in = 16'(s); delay_len = AW'(dl); feedback = 8'(fb); mix = 8'(mx); smp_valid = 1;
    @(posedge clk); #1 smp_valid = 0;
    ra = o_ra;
    if (push) begin
      d = dl == 0 ? 1 : dl > ref_depth - 1 ? ref_depth - 1 : dl;
      r = ref_wptr >= d ? ref_wptr - d : ref_wptr + ref_depth - d;
      wet = ref_mem[r];
      f = sat(s + ((wet * fb) >>> 8));
      m = sat((s * (256 - mx) + wet * mx) >>> 8);
      ref_mem[ref_wptr] = f;
      exp_q.push_back('{out: 16'(m), wd: 16'(f), wa: AW'(ref_wptr), ra: AW'(r)});
      ref_wptr = ref_wptr == ref_depth - 1 ? 0 : ref_wptr + 1;
    end
  endtask

  task automatic wait_out(output bit ok, output int cyc);
    ok = 0; cyc = 0;
    for (int i = 0; i < 8; i++) begin
      if (o_valid) begin ok = 1; break; end
      @(posedge clk); #1 cyc++;
    end
  endtask

  task automatic pulse_reset();
    rst = 1;
    @(posedge clk); #1 rst = 0;
  endtask

  task automatic test_reset();
    int bad = 0;
    rst = 1;
    @(posedge clk); #1;
    n_cmp++;
    if (o_out !== 0 || o_valid !== 0 || o_ready !== 0 || o_ovr !== 0 || o_wen !== 0 || o_ra !== 0) begin
      n_fail++;
      $display("FAIL reset_values: out=%h valid=%b ready=%b ovr=%b wen=%b ra=%0d required all 0",
               o_out, o_valid, o_ready, o_ovr, o_wen, o_ra);
    end
    rst = 0;
    for (int i = 0; i < DEPTH; i++) begin
      @(posedge clk); #1;
      if (o_wen !== 1 || o_wa !== AW'(i) || o_din !== 0 || o_ready !== 0 || o_valid !== 0) begin
        if (bad == 0) $display("FAIL clear_sweep at %0d: wen=%b addr=%0d din=%h ready=%b required 1/%0d/0/0",
                               i, o_wen, o_wa, o_din, o_ready, i);
        bad++;
      end
    end
    n_cmp++;
    if (bad != 0) n_fail++;
    @(posedge clk); #1;
    n_cmp++;
    if (o_ready !== 1 || o_wen !== 0) begin
      n_fail++;
      $display("FAIL clear_done: ready=%b wen=%b required 1/0", o_ready, o_wen);
    end
    model_reset(DEPTH);
  endtask

  task automatic test_mix_echo();
    logic [AW-1:0] ra; bit ok; int cyc; exp_t e; logic [15:0] lit;
    for (int k = 0; k < 8; k++) begin
      drive(k == 0 ? 16'h4000 : 0, 4, 0, 128, 1, ra);
      wait_out(ok, cyc);
      e = exp_q.pop_front();
      lit = (k == 0 || k == 4) ? 16'h2000 : 16'h0000;
      n_cmp++;
      if (!ok || cyc != 2 || o_out !== lit || o_out !== e.out || o_din !== e.wd || o_wa !== e.wa || o_wen !== 1 || ra !== e.ra) begin
        n_fail++;
        $display("FAIL mix_echo k=%0d: ok=%b lat=%0d out=%h din=%h wa=%0d ra=%0d required lat 2 out=%h din=%h wa=%0d ra=%0d",
                 k, ok, cyc, o_out, o_din, o_wa, ra, lit, e.wd, e.wa, e.ra);
      end
    end
  endtask

  task automatic test_feedback();
    logic [AW-1:0] ra; bit ok; int cyc;
    logic [15:0] lit_din [5] = '{16'h4000, 16'h0, 16'h2000, 16'h0, 16'h1000};
    logic [15:0] lit_out [5] = '{16'h4000, 16'h0, 16'h0, 16'h0, 16'h0};
    exp_t e;
    for (int k = 0; k < 5; k++) begin
      drive(k == 0 ? 16'h4000 : 0, 2, 128, 0, 1, ra);
      wait_out(ok, cyc);
      e = exp_q.pop_front();
      n_cmp++;
      if (!ok || o_din !== lit_din[k] || o_out !== lit_out[k] || o_wa !== e.wa || ra !== e.ra) begin
        n_fail++;
        $display("FAIL feedback k=%0d: ok=%b din=%h out=%h wa=%0d required din=%h out=%h wa=%0d",
                 k, ok, o_din, o_out, o_wa, lit_din[k], lit_out[k], e.wa);
      end
    end
  endtask

  task automatic test_saturation();
    logic [AW-1:0] ra; bit ok; int cyc; exp_t e;
    int smp [4] = '{32767, 32767, -32768, -32768};
    logic [15:0] lit [4] = '{16'h7fff, 16'h7fff, 16'hff7f, 16'h8000};
    for (int k = 0; k < 4; k++) begin
      drive(smp[k], 1, 255, 0, 1, ra);
      wait_out(ok, cyc);
      e = exp_q.pop_front();
      n_cmp++;
      if (!ok || o_din !== lit[k] || o_din !== e.wd || o_out !== e.out || o_wa !== e.wa) begin
        n_fail++;
        $display("FAIL saturation k=%0d: ok=%b din=%h out=%h required din=%h out=%h", k, ok, o_din, o_out, lit[k], e.out);
      end
    end
  endtask

  task automatic test_random();
    logic [AW-1:0] ra; bit ok; int cyc; exp_t e; int dl;
    for (int k = 0; k < 24; k++) begin
      dl = (k % 3 == 0) ? int'($urandom_range(32767, 29270)) : int'($urandom_range(40, 0));
      drive(int'($urandom_range(65535)) - 32768, dl, int'($urandom_range(255)), int'($urandom_range(255)), 1, ra);
      wait_out(ok, cyc);
      e = exp_q.pop_front();
      n_cmp++;
      if (!ok || o_out !== e.out || o_din !== e.wd || o_wa !== e.wa || ra !== e.ra || o_wen !== 1) begin
        n_fail++;
        $display("FAIL random k=%0d dl=%0d: ok=%b out=%h din=%h wa=%0d ra=%0d required out=%h din=%h wa=%0d ra=%0d",
                 k, dl, ok, o_out, o_din, o_wa, ra, e.out, e.wd, e.wa, e.ra);
      end
    end
  endtask

  task automatic test_wrap_small();
    logic [AW-1:0] ra; bit ok; int cyc; exp_t e; int dl;
    logic [AW-1:0] lit_ra;
    use_small = 1;
    pulse_reset();
    model_reset(SD);
    for (int k = 0; k < 12; k++) begin
      dl = k < 10 ? 3 : k == 10 ? 0 : 100;
      drive(1000 * (k + 1), dl, 64, 64, 1, ra);
      wait_out(ok, cyc);
      e = exp_q.pop_front();
      lit_ra = k == 9 ? AW'(6) : k == 10 ? AW'(1) : k == 11 ? AW'(4) : e.ra;
      n_cmp++;
      if (!ok || o_wa !== AW'(k % 8) || ra !== lit_ra || ra !== e.ra || o_out !== e.out || o_din !== e.wd) begin
        n_fail++;
        $display("FAIL wrap_small k=%0d: ok=%b wa=%0d ra=%0d out=%h din=%h required wa=%0d ra=%0d out=%h din=%h",
                 k, ok, o_wa, ra, o_out, o_din, k % 8, lit_ra, e.out, e.wd);
      end
    end
    use_small = 0;
    pulse_reset();
    model_reset(DEPTH);
  endtask

  task automatic test_overrun();
    logic [AW-1:0] ra; exp_t e; int stray = 0; bit ok; int cyc;
    drive(16'h1111, 5, 100, 200, 1, ra);
    @(posedge clk); #1;
    smp_in = 16'h7777; smp_valid = 1;
    @(posedge clk); #1 smp_valid = 0;
    e = exp_q.pop_front();
    n_cmp++;
    if (o_ovr !== 1 || o_valid !== 1 || o_out !== e.out || o_din !== e.wd || o_wa !== e.wa) begin
      n_fail++;
      $display("FAIL overrun_pulse: ovr=%b valid=%b out=%h din=%h required 1/1 out=%h din=%h",
               o_ovr, o_valid, o_out, o_din, e.out, e.wd);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (o_ovr !== 0 || o_ready !== 1) begin
      n_fail++;
      $display("FAIL overrun_clear: ovr=%b ready=%b required 0/1", o_ovr, o_ready);
    end
    for (int i = 0; i < 6; i++) begin
      if (o_valid) stray++;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (stray != 0) begin
      n_fail++;
      $display("FAIL overrun_dropped: out_valid cycles=%0d required 0", stray);
    end
    drive(16'h0200, 1, 128, 128, 1, ra);
    wait_out(ok, cyc);
    e = exp_q.pop_front();
    n_cmp++;
    if (!ok || o_out !== e.out || o_din !== e.wd || o_wa !== e.wa || ra !== e.ra) begin
      n_fail++;
      $display("FAIL overrun_after: ok=%b out=%h din=%h wa=%0d required out=%h din=%h wa=%0d",
               ok, o_out, o_din, o_wa, e.out, e.wd, e.wa);
    end
  endtask

  task automatic test_reset_in_calc();
    logic [AW-1:0] ra; int stray = 0;
    drive(16'h3333, 3, 0, 128, 0, ra);
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1;
    n_cmp++;
    if (o_valid !== 0 || o_wen !== 0 || o_ready !== 0) begin
      n_fail++;
      $display("FAIL rst_calc: valid=%b wen=%b ready=%b required 0/0/0", o_valid, o_wen, o_ready);
    end
    rst = 0;
    @(posedge clk); #1;
    n_cmp++;
    if (o_wen !== 1 || o_wa !== 0 || o_din !== 0) begin
      n_fail++;
      $display("FAIL rst_calc_clear: wen=%b wa=%0d din=%h required 1/0/0", o_wen, o_wa, o_din);
    end
    for (int i = 0; i < 6; i++) begin
      if (o_valid) stray++;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (stray != 0) begin
      n_fail++;
      $display("FAIL rst_calc_no_out: out_valid cycles=%0d required 0", stray);
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) bmem[i] = 16'h5a5a;
    for (int i = 0; i < SD; i++) smem[i] = 16'ha5a5;
    test_reset();
    test_mix_echo();
    test_feedback();
    test_saturation();
    test_random();
    test_wrap_small();
    test_overrun();
    test_reset_in_calc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
